// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default frame
// geometry and the oversample tick positions used inside each bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int MID_TICK        = 7;
  localparam int END_TICK        = 15;

  // A two-stop-bit setting (32 ticks) needs a wider oversample counter.
  function automatic int s_width(input int sb_tick);
    return (sb_tick > 16) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver. Define UART_RX_PARITY_EN to receive an even
// parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int SW = s_width(SB_TICK);
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_END  = SW'(END_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  state_t            state;
  logic [SW-1:0]     s;
  logic [2:0]        n;
  logic [DBIT-1:0]   b;
  logic              rx_s;
  logic              fe_q;
`ifdef UART_RX_PARITY_EN
  logic              pe_q;
`endif

  uart_sync2 u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Status is captured inside the FSM and published to the outputs on the
  // cycle after rx_done_tick, so all three change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      fe_q         <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q         <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      if (rx_done_tick) begin
        dout       <= 8'(b);
        frame_err  <= fe_q;
`ifdef UART_RX_PARITY_EN
        parity_err <= pe_q;
`endif
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                s     <= '0;
                n     <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_END) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_END) begin
              pe_q  <= (^b) ^ rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              fe_q         <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
